// File: rtl/arb4_rr_pkg.sv
// Shared types and constants for the 4-way round-robin arbiter.
package arb4_rr_pkg;

  localparam int unsigned NumReq = 4;
  localparam int unsigned IdxW   = 2;

  typedef logic [IdxW-1:0] idx_t;

  typedef enum logic {
    StIdle  = 1'b0,
    StOwned = 1'b1
  } state_e;

  // Modulo-NumReq index addition; relies on idx_t wrapping naturally.
  function automatic idx_t idx_add(idx_t base, idx_t off);
    return base + off;
  endfunction

endpackage

// File: rtl/arb4_rr_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface arb4_rr_if;
  import arb4_rr_pkg::*;

  logic [NumReq-1:0] req;
  logic              done;
  logic [NumReq-1:0] gnt;
  idx_t              gnt_id;
  logic              gnt_valid;
  logic              timeout;

  modport master (
    output req,
    output done,
    input  gnt,
    input  gnt_id,
    input  gnt_valid,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output gnt,
    output gnt_id,
    output gnt_valid,
    output timeout
  );

endinterface

// File: rtl/arb4_rr_prio_enc4.sv
// Fixed-priority encoder over an already rotated request vector; bit 0 wins.
module rr_prio_enc4
  import arb4_rr_pkg::*;
(
  input  logic [NumReq-1:0] req_i,
  output idx_t              idx_o,
  output logic              valid_o
);

  // Lowest set bit wins; idx_o is 0 when nothing is requested.
  always_comb begin
    idx_o   = '0;
    valid_o = |req_i;
    if (req_i[0]) begin
      idx_o = 2'd0;
    end else if (req_i[1]) begin
      idx_o = 2'd1;
    end else if (req_i[2]) begin
      idx_o = 2'd2;
    end else if (req_i[3]) begin
      idx_o = 2'd3;
    end
  end

endmodule

// File: rtl/arb4_rr.sv
// 4-requester round-robin arbiter with hold-time limit and forced release.
module arb4_rr
  import arb4_rr_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic      clk,
  input  logic      rst_n,
  arb4_rr_if.slave  bus
);

  localparam logic [7:0] HoldLast = 8'(MAX_HOLD - 1);

  state_e            state_q, state_d;
  logic [NumReq-1:0] gnt_q, gnt_d;
  idx_t              gnt_id_q, gnt_id_d;
  idx_t              last_q, last_d;
  logic [7:0]        hold_q, hold_d;
  logic              timeout_q, timeout_d;
  // Low for the first edge after reset release so grants start on the second edge.
  logic              run_q;

  logic [NumReq-1:0] req_m, req_rot;
  idx_t              start, enc_idx, win_id;
  logic              enc_valid;
  logic              hold_hit, release_ev;

  // Mask the releasing owner, then rotate so the search begins after last_id.
  always_comb begin
    req_m = bus.req;
    if (state_q == StOwned) begin
      req_m[gnt_id_q] = 1'b0;
    end
    start = idx_add(last_q, idx_t'(1));
    for (int k = 0; k < NumReq; k++) begin
      req_rot[k] = req_m[idx_add(start, idx_t'(k))];
    end
  end

  rr_prio_enc4 u_enc (
    .req_i   (req_rot),
    .idx_o   (enc_idx),
    .valid_o (enc_valid)
  );

  assign win_id     = idx_add(start, enc_idx);
  assign hold_hit   = (hold_q == HoldLast);
  assign release_ev = bus.done | ~bus.req[gnt_id_q] | hold_hit;

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    last_d    = last_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (run_q && enc_valid) begin
          state_d  = StOwned;
          gnt_d    = 4'(1) << win_id;
          gnt_id_d = win_id;
          last_d   = win_id;
          hold_d   = '0;
        end
      end
      StOwned: begin
        if (release_ev) begin
          // A coincident done makes this a normal release.
          timeout_d = hold_hit & ~bus.done;
          if (enc_valid) begin
            gnt_d    = 4'(1) << win_id;
            gnt_id_d = win_id;
            last_d   = win_id;
            hold_d   = '0;
          end else begin
            state_d  = StIdle;
            gnt_d    = '0;
            gnt_id_d = '0;
            hold_d   = '0;
          end
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      last_q    <= 2'd3;
      hold_q    <= '0;
      timeout_q <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      last_q    <= last_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
      run_q     <= 1'b1;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_id    = gnt_id_q;
  assign bus.gnt_valid = |gnt_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_arb4_rr.sv
// Directed bench for arb4_rr with MAX_HOLD=4.
module tb_arb4_rr;

  logic clk = 1'b0;
  logic rst_n;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  arb4_rr_if bus ();

  arb4_rr #(.MAX_HOLD(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b ({gnt,id,valid,timeout})", tag, act, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [3:0] g, input logic [1:0] id,
                            input logic to);
    check_eq(tag, {bus.gnt, bus.gnt_id, bus.gnt_valid, bus.timeout}, {g, id, |g, to});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    bus.req  = 4'b0000;
    bus.done = 1'b0;
    #2;
    expect_out("reset_async", 4'b0000, 2'd0, 1'b0);
    bus.req = 4'b0101;
    step();
    expect_out("reset_held", 4'b0000, 2'd0, 1'b0);
    rst_n = 1'b1;

    // Reset release: first edge only arms, second edge grants.
    step();
    expect_out("rel_edge1", 4'b0000, 2'd0, 1'b0);
    step();
    expect_out("alt_g0", 4'b0001, 2'd0, 1'b0);
    bus.done = 1'b1;
    step();
    expect_out("alt_g2", 4'b0100, 2'd2, 1'b0);
    step();
    expect_out("alt_g0b", 4'b0001, 2'd0, 1'b0);
    step();
    expect_out("alt_g2b", 4'b0100, 2'd2, 1'b0);
    bus.done = 1'b0;
    bus.req  = 4'b0000;
    step();
    expect_out("alt_idle", 4'b0000, 2'd0, 1'b0);
    bus.done = 1'b1;
    step();
    expect_out("idle_done", 4'b0000, 2'd0, 1'b0);

    // All four requesting, done every grant: 0,1,2,3,0.
    bus.done = 1'b0;
    apply_reset();
    bus.req  = 4'b1111;
    bus.done = 1'b1;
    step();
    expect_out("rr_arm", 4'b0000, 2'd0, 1'b0);
    step();
    expect_out("rr_0", 4'b0001, 2'd0, 1'b0);
    step();
    expect_out("rr_1", 4'b0010, 2'd1, 1'b0);
    step();
    expect_out("rr_2", 4'b0100, 2'd2, 1'b0);
    step();
    expect_out("rr_3", 4'b1000, 2'd3, 1'b0);
    step();
    expect_out("rr_0b", 4'b0001, 2'd0, 1'b0);
    bus.req  = 4'b0000;
    bus.done = 1'b0;
    step();
    expect_out("rr_idle", 4'b0000, 2'd0, 1'b0);

    // Lone requester with no done: 4 grant cycles, timeout gap, re-grant.
    apply_reset();
    bus.req = 4'b0010;
    step();
    step();
    expect_out("to_h0", 4'b0010, 2'd1, 1'b0);
    step();
    expect_out("to_h1", 4'b0010, 2'd1, 1'b0);
    step();
    expect_out("to_h2", 4'b0010, 2'd1, 1'b0);
    step();
    expect_out("to_h3", 4'b0010, 2'd1, 1'b0);
    step();
    expect_out("to_pulse", 4'b0000, 2'd0, 1'b1);
    step();
    expect_out("to_regrant", 4'b0010, 2'd1, 1'b0);

    // Owner 1 drops its request while 3 waits.
    bus.req = 4'b1000;
    step();
    expect_out("drop_to_3", 4'b1000, 2'd3, 1'b0);
    bus.req = 4'b0000;
    step();
    expect_out("drop_idle", 4'b0000, 2'd0, 1'b0);

    // Reset mid-grant drops gnt without waiting for a clock edge.
    apply_reset();
    bus.req = 4'b0100;
    step();
    step();
    expect_out("mid_g2", 4'b0100, 2'd2, 1'b0);
    rst_n = 1'b0;
    #2;
    expect_out("mid_rst", 4'b0000, 2'd0, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    expect_out("mid_arm", 4'b0000, 2'd0, 1'b0);
    step();
    expect_out("mid_regrant", 4'b0100, 2'd2, 1'b0);

    // done coinciding with hold limit: normal release to requester 1.
    bus.req = 4'b0110;
    step();
    step();
    step();
    expect_out("co_h3", 4'b0100, 2'd2, 1'b0);
    bus.done = 1'b1;
    step();
    expect_out("co_next", 4'b0010, 2'd1, 1'b0);
    bus.done = 1'b0;

    // Forced release with another requester pending: switch and pulse.
    step();
    step();
    step();
    expect_out("fr_h3", 4'b0010, 2'd1, 1'b0);
    step();
    expect_out("fr_switch", 4'b0100, 2'd2, 1'b1);
    step();
    expect_out("fr_after", 4'b0100, 2'd2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
